// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle signed restoring divider.
// A 2*WIDTH-bit signed dividend is divided by a WIDTH-bit signed divisor.
// The quotient is truncated toward zero, and the remainder takes the sign
// of the dividend. If the quotient does not fit in WIDTH bits, it saturates
// and the overflow flag is set.
// Optional feature macro: DIV_ZERO_DETECT_EN (early zero-divisor exit, div_by_zero flag).
//
// Handshake: start is sampled only in IDLE; inputs are captured on that edge.
// busy is high in PREP, RUN and FIX. done is high for the single DONE cycle,
// while busy is low, and the results are already stable then. Results hold
// until the next FIX or reset. A start seen outside IDLE is dropped.
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 overflow,
  output logic                 div_by_zero,
  output logic [2:0]           state_dbg
);

  localparam int DW = 2 * WIDTH;
  localparam logic [6:0] LAST_ITER = 7'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]    dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] dvs_abs;
  logic [DW-1:0]    prem;      // partial remainder (pre-shift)
  logic [DW-1:0]    qacc;      // dividend magnitude shifting out, quotient bits shifting in
  logic [6:0]       iter;
  logic             sign_q;
  logic             sign_r;
  logic [DW:0]      diff;
  logic             q_ovf;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

`ifdef DIV_ZERO_DETECT_EN
  logic dvs_zero;
  logic dbz_reg;
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_PREP;
`ifdef DIV_ZERO_DETECT_EN
      S_PREP: state_nxt = (dvs_reg == '0) ? S_FIX : S_RUN;
`else
      S_PREP: state_nxt = S_RUN;
`endif
      S_RUN:  if (iter == LAST_ITER) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_PREP, S_RUN, S_FIX: busy = 1'b1;
      S_DONE:               done = 1'b1;
      default: ;
    endcase
  end

  // One restoring step: shift the next dividend bit in, then trial-subtract |divisor|
  always_comb begin
    diff = {prem, qacc[DW-1]} - {{(WIDTH+1){1'b0}}, dvs_abs};
  end

  // Overflow test on the magnitude, then sign correction or saturation
  always_comb begin
    if (sign_q)
      q_ovf = (|qacc[DW-1:WIDTH]) | (qacc[WIDTH-1] & (|qacc[WIDTH-2:0]));
    else
      q_ovf = |qacc[DW-1:WIDTH-1];
    if (q_ovf) begin
      fix_q = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      fix_r = '0;
    end else begin
      fix_q = sign_q ? -qacc[WIDTH-1:0] : qacc[WIDTH-1:0];
      fix_r = sign_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    end
  end

  // Datapath: capture, magnitude prep, iteration, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      dvs_abs   <= '0;
      prem      <= '0;
      qacc      <= '0;
      iter      <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      overflow  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dvs_zero  <= 1'b0;
      dbz_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
          end
        end
        S_PREP: begin
          sign_q  <= dvd_reg[DW-1] ^ dvs_reg[WIDTH-1];
          sign_r  <= dvd_reg[DW-1];
          qacc    <= dvd_reg[DW-1] ? -dvd_reg : dvd_reg;
          dvs_abs <= dvs_reg[WIDTH-1] ? -dvs_reg : dvs_reg;
          prem    <= '0;
          iter    <= '0;
`ifdef DIV_ZERO_DETECT_EN
          dvs_zero <= (dvs_reg == '0);
`endif
        end
        S_RUN: begin
          if (diff[DW]) prem <= {prem[DW-2:0], qacc[DW-1]};
          else          prem <= diff[DW-1:0];
          qacc <= {qacc[DW-2:0], ~diff[DW]};
          iter <= iter + 7'd1;
        end
        S_FIX: begin
`ifdef DIV_ZERO_DETECT_EN
          if (dvs_zero) begin
            quotient  <= '1;
            remainder <= dvd_reg[WIDTH-1:0];
            overflow  <= 1'b0;
            dbz_reg   <= 1'b1;
          end else begin
            quotient  <= fix_q;
            remainder <= fix_r;
            overflow  <= q_ovf;
            dbz_reg   <= 1'b0;
          end
`else
          quotient  <= fix_q;
          remainder <= fix_r;
          overflow  <= q_ovf;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
